vend_controller: RTL and testbench

Transaction sequencer for the vending datapath. It consumes the running `total_currency` and `currency_ready` strobe from the currency handler, tracks per-transaction credit, and latches an item selection. It then issues a dispense request with a ready/valid handshake, and returns change or a refund. It sits between the currency handler and the dispenser/change-return units, in the system clock domain.

---
 rtl/vend_pkg.sv | 21 ++
 rtl/vend_if.sv | 29 ++
 rtl/vend_credit_tracker.sv | 26 ++
 rtl/vend_controller.sv | 147 ++++++++++++++
 tb/tb_vend_controller.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared state encoding, item index width and price ROM for the vending transaction sequencer.
package vend_pkg;

  localparam int unsigned ITEM_W        = 2;
  localparam int unsigned PRICE_ENTRIES = 4;

  typedef logic [1:0] vend_state_t;

  localparam vend_state_t ST_IDLE     = 2'd0;
  localparam vend_state_t ST_PAY      = 2'd1;
  localparam vend_state_t ST_DISPENSE = 2'd2;
  localparam vend_state_t ST_SETTLE   = 2'd3;

  localparam int unsigned PRICE_TABLE [PRICE_ENTRIES] = '{15, 25, 40, 60};

  // Callers narrow the result to their currency width.
  function automatic int unsigned item_price(input logic [ITEM_W-1:0] idx);
    return PRICE_TABLE[idx];
  endfunction

endpackage

// File: rtl/vend_if.sv
// Currency, selection, dispense and change signals between the vend controller and its neighbours.
interface vend_if import vend_pkg::*; #(
  parameter int unsigned CURRENCY_WIDTH = 7
) ();

  logic [CURRENCY_WIDTH-1:0] total_currency;
  logic                      currency_ready;
  logic [ITEM_W-1:0]         item_sel;
  logic                      item_sel_valid;
  logic                      cancel;
  logic                      dispense_ready;
  logic                      dispense_valid;
  logic [ITEM_W-1:0]         dispense_item;
  logic                      change_valid;
  logic [CURRENCY_WIDTH-1:0] change_value;
  logic [CURRENCY_WIDTH-1:0] credit;
  logic                      busy;

  modport slave (
    input  total_currency, currency_ready, item_sel, item_sel_valid, cancel, dispense_ready,
    output dispense_valid, dispense_item, change_valid, change_value, credit, busy
  );

  modport master (
    output total_currency, currency_ready, item_sel, item_sel_valid, cancel, dispense_ready,
    input  dispense_valid, dispense_item, change_valid, change_value, credit, busy
  );

endinterface

// File: rtl/vend_credit_tracker.sv
// Per-transaction credit as the modulo distance from a snapshot of the free-running currency total.
module vend_credit_tracker #(
  parameter int unsigned CURRENCY_WIDTH = 7
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CURRENCY_WIDTH-1:0] i_total,
  input  logic                      i_settle,
  input  logic [CURRENCY_WIDTH-1:0] i_consumed,
  output logic [CURRENCY_WIDTH-1:0] o_credit_c
);

  logic [CURRENCY_WIDTH-1:0] r_base;

  // Only the consumed amount advances the base, so a coin landing on the settle cycle stays as credit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base <= i_total;
    end else if (i_settle) begin
      r_base <= r_base + i_consumed;
    end
  end

  assign o_credit_c = i_total - r_base;

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: IDLE -> PAY -> DISPENSE -> SETTLE with refund on cancel.
// Define VEND_TIMEOUT_EN to refund automatically after TIMEOUT_CYCLES of PAY inactivity.
module vend_controller import vend_pkg::*; #(
  parameter int unsigned CURRENCY_WIDTH = 7,
  parameter int unsigned NUM_ITEMS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic   i_clk,
  input logic   i_rst,
  vend_if.slave bus
);

  if (NUM_ITEMS == 0 || NUM_ITEMS > PRICE_ENTRIES || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("vend_controller: unsupported NUM_ITEMS or TIMEOUT_CYCLES");
  end

  vend_state_t               r_state;
  vend_state_t               w_next_state;
  logic                      r_dispense_valid;
  logic [ITEM_W-1:0]         r_dispense_item;
  logic                      r_change_valid;
  logic [CURRENCY_WIDTH-1:0] r_change_value;
  logic                      r_busy;
  logic [CURRENCY_WIDTH-1:0] r_price;
  logic [CURRENCY_WIDTH-1:0] r_consumed;
  logic [CURRENCY_WIDTH-1:0] w_credit;
  logic [CURRENCY_WIDTH-1:0] w_change_next;
  logic [CURRENCY_WIDTH-1:0] w_consumed_next;
  logic                      w_settle_load;
  logic                      w_sel_load;
  logic                      w_sel_ok;
  logic                      w_tmo_expire;

  vend_credit_tracker #(.CURRENCY_WIDTH(CURRENCY_WIDTH)) u_credit (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_total    (bus.total_currency),
    .i_settle   (r_state == ST_SETTLE),
    .i_consumed (r_consumed),
    .o_credit_c (w_credit)
  );

  assign w_sel_ok = 32'(bus.item_sel) < NUM_ITEMS;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] r_tmo_cnt;

  // Inactivity counter: held at zero outside PAY so it is clear on entry, restarted by any coin.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != ST_PAY || bus.currency_ready) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo_expire = (r_state == ST_PAY) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_expire = 1'b0;
`endif

  // Next-state and settle-amount decode.
  always_comb begin
    w_next_state    = r_state;
    w_settle_load   = 1'b0;
    w_sel_load      = 1'b0;
    w_change_next   = '0;
    w_consumed_next = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cancel && w_credit != '0) begin
          w_next_state    = ST_SETTLE;
          w_settle_load   = 1'b1;
          w_change_next   = w_credit;
          w_consumed_next = w_credit;
        end else if (bus.item_sel_valid && w_sel_ok) begin
          w_next_state = ST_PAY;
          w_sel_load   = 1'b1;
        end
      end
      ST_PAY: begin
        if (bus.cancel || w_tmo_expire) begin
          w_next_state    = ST_SETTLE;
          w_settle_load   = 1'b1;
          w_change_next   = w_credit;
          w_consumed_next = w_credit;
        end else if (w_credit >= r_price) begin
          w_next_state = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        // Live credit so coins arriving while waiting on the dispenser are returned.
        if (bus.dispense_ready) begin
          w_next_state    = ST_SETTLE;
          w_settle_load   = 1'b1;
          w_change_next   = w_credit - r_price;
          w_consumed_next = w_credit;
        end
      end
      ST_SETTLE: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dispense_valid <= 1'b0;
      r_dispense_item  <= '0;
      r_change_valid   <= 1'b0;
      r_change_value   <= '0;
      r_busy           <= 1'b0;
      r_price          <= '0;
      r_consumed       <= '0;
    end else begin
      r_dispense_valid <= (w_next_state == ST_DISPENSE);
      r_change_valid   <= w_settle_load;
      r_busy           <= (w_next_state != ST_IDLE);
      if (w_sel_load) begin
        r_dispense_item <= bus.item_sel;
        r_price         <= CURRENCY_WIDTH'(item_price(bus.item_sel));
      end
      if (w_settle_load) begin
        r_change_value <= w_change_next;
        r_consumed     <= w_consumed_next;
      end
    end
  end

  assign bus.dispense_valid = r_dispense_valid;
  assign bus.dispense_item  = r_dispense_item;
  assign bus.change_valid   = r_change_valid;
  assign bus.change_value   = r_change_value;
  assign bus.credit         = w_credit;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller; a second instance with NUM_ITEMS = 3 covers out-of-range selection.
module tb_vend_controller;

  localparam int unsigned CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] total;
  int            n_pass  = 0;
  int            n_total = 0;

  vend_if #(.CURRENCY_WIDTH(CW)) bus  ();
  vend_if #(.CURRENCY_WIDTH(CW)) bus3 ();

  vend_controller #(.CURRENCY_WIDTH(CW), .NUM_ITEMS(4), .TIMEOUT_CYCLES(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  vend_controller #(.CURRENCY_WIDTH(CW), .NUM_ITEMS(3), .TIMEOUT_CYCLES(8)) dut3 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int amt);
    total = total + CW'(amt);
    bus.total_currency = total;
    bus.currency_ready = 1'b1;
    tick();
    bus.currency_ready = 1'b0;
  endtask

  task automatic select(input int idx);
    bus.item_sel       = 2'(idx);
    bus.item_sel_valid = 1'b1;
    tick();
    bus.item_sel_valid = 1'b0;
  endtask

  task automatic test_reset();
    total = 7'd100;
    bus.total_currency = total;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_total++; if (bus.credit !== 7'd0) $display("FAIL reset_credit: got %0d expected 0", bus.credit); else n_pass++;
    n_total++; if (bus.dispense_valid !== 1'b0) $display("FAIL reset_dispense_valid: got %0b expected 0", bus.dispense_valid); else n_pass++;
    n_total++; if (bus.change_valid !== 1'b0) $display("FAIL reset_change_valid: got %0b expected 0", bus.change_valid); else n_pass++;
    n_total++; if (bus.change_value !== 7'd0) $display("FAIL reset_change_value: got %0d expected 0", bus.change_value); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy); else n_pass++;
    n_total++; if (bus.dispense_item !== 2'd0) $display("FAIL reset_dispense_item: got %0d expected 0", bus.dispense_item); else n_pass++;
    tick();
    n_total++; if (bus.credit !== 7'd0) $display("FAIL post_reset_credit: got %0d expected 0", bus.credit); else n_pass++;
  endtask

  // Item 1 (25) paid exactly from base 100.
  task automatic test_exact_pay();
    select(1);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL exact_busy_pay: got %0b expected 1", bus.busy); else n_pass++;
    n_total++; if (bus.dispense_valid !== 1'b0) $display("FAIL exact_no_early_dispense: got %0b expected 0", bus.dispense_valid); else n_pass++;
    coin(25);
    n_total++; if (bus.dispense_valid !== 1'b1) $display("FAIL exact_dispense_valid: got %0b expected 1", bus.dispense_valid); else n_pass++;
    n_total++; if (bus.dispense_item !== 2'd1) $display("FAIL exact_dispense_item: got %0d expected 1", bus.dispense_item); else n_pass++;
    bus.dispense_ready = 1'b1;
    tick();
    bus.dispense_ready = 1'b0;
    n_total++; if (bus.change_valid !== 1'b1) $display("FAIL exact_change_valid: got %0b expected 1", bus.change_valid); else n_pass++;
    n_total++; if (bus.change_value !== 7'd0) $display("FAIL exact_change_value: got %0d expected 0", bus.change_value); else n_pass++;
    n_total++; if (bus.dispense_valid !== 1'b0) $display("FAIL exact_dispense_drop: got %0b expected 0", bus.dispense_valid); else n_pass++;
    tick();
    n_total++; if (bus.change_valid !== 1'b0) $display("FAIL exact_change_one_shot: got %0b expected 0", bus.change_valid); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL exact_busy_idle: got %0b expected 0", bus.busy); else n_pass++;
    n_total++; if (bus.credit !== 7'd0) $display("FAIL exact_credit_consumed: got %0d expected 0", bus.credit); else n_pass++;
  endtask

  // Item 0 (15) with 20 inserted, dispenser stalls for 5 cycles.
  task automatic test_hold_stall();
    select(0);
    coin(20);
    bus.dispense_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (bus.dispense_valid !== 1'b1 || bus.dispense_item !== 2'd0) $display("FAIL hold_stable_%0d: got valid=%0b item=%0d expected valid=1 item=0", i, bus.dispense_valid, bus.dispense_item); else n_pass++;
      tick();
    end
    bus.dispense_ready = 1'b1;
    tick();
    bus.dispense_ready = 1'b0;
    n_total++; if (bus.change_valid !== 1'b1 || bus.change_value !== 7'd5) $display("FAIL hold_change: got valid=%0b value=%0d expected valid=1 value=5", bus.change_valid, bus.change_value); else n_pass++;
    tick();
  endtask

  // Base 120; total wraps to 22 after coins of 10 and 20.
  task automatic test_wrap();
    total = 7'd120;
    bus.total_currency = total;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    coin(10);
    coin(20);
    n_total++; if (bus.credit !== 7'd30) $display("FAIL wrap_credit: got %0d expected 30", bus.credit); else n_pass++;
    select(1);
    tick();
    n_total++; if (bus.dispense_valid !== 1'b1 || bus.dispense_item !== 2'd1) $display("FAIL wrap_dispense: got valid=%0b item=%0d expected valid=1 item=1", bus.dispense_valid, bus.dispense_item); else n_pass++;
    bus.dispense_ready = 1'b1;
    tick();
    bus.dispense_ready = 1'b0;
    n_total++; if (bus.change_value !== 7'd5) $display("FAIL wrap_change: got %0d expected 5", bus.change_value); else n_pass++;
    tick();
    n_total++; if (bus.credit !== 7'd0) $display("FAIL wrap_credit_after: got %0d expected 0", bus.credit); else n_pass++;
  endtask

  // Item 3 (60): cancel on the same cycle a coin reaches the price.
  task automatic test_cancel_race();
    select(3);
    coin(30);
    total = total + 7'd30;
    bus.total_currency = total;
    bus.currency_ready = 1'b1;
    bus.cancel         = 1'b1;
    tick();
    bus.currency_ready = 1'b0;
    bus.cancel         = 1'b0;
    n_total++; if (bus.dispense_valid !== 1'b0) $display("FAIL race_no_dispense: got %0b expected 0", bus.dispense_valid); else n_pass++;
    n_total++; if (bus.change_valid !== 1'b1 || bus.change_value !== 7'd60) $display("FAIL race_refund: got valid=%0b value=%0d expected valid=1 value=60", bus.change_valid, bus.change_value); else n_pass++;
    tick();
    n_total++; if (bus.busy !== 1'b0 || bus.credit !== 7'd0) $display("FAIL race_idle: got busy=%0b credit=%0d expected busy=0 credit=0", bus.busy, bus.credit); else n_pass++;
  endtask

  // IDLE cancel rules and a coin landing on the settle cycle.
  task automatic test_idle_cancel();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    n_total++; if (bus.change_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL idle_cancel_zero: got change_valid=%0b busy=%0b expected 0 0", bus.change_valid, bus.busy); else n_pass++;
    coin(10);
    bus.cancel         = 1'b1;
    bus.item_sel       = 2'd0;
    bus.item_sel_valid = 1'b1;
    tick();
    bus.cancel         = 1'b0;
    bus.item_sel_valid = 1'b0;
    n_total++; if (bus.change_valid !== 1'b1 || bus.change_value !== 7'd10) $display("FAIL idle_cancel_wins: got valid=%0b value=%0d expected valid=1 value=10", bus.change_valid, bus.change_value); else n_pass++;
    coin(5);
    n_total++; if (bus.credit !== 7'd5 || bus.busy !== 1'b0) $display("FAIL settle_coin_kept: got credit=%0d busy=%0b expected credit=5 busy=0", bus.credit, bus.busy); else n_pass++;
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    n_total++; if (bus.change_valid !== 1'b1 || bus.change_value !== 7'd5) $display("FAIL settle_coin_refund: got valid=%0b value=%0d expected valid=1 value=5", bus.change_valid, bus.change_value); else n_pass++;
    tick();
  endtask

  // Coin and cancel while waiting on the dispenser: cancel ignored, coin returned as change.
  task automatic test_dispense_extra();
    select(0);
    coin(15);
    n_total++; if (bus.dispense_valid !== 1'b1) $display("FAIL extra_dispense: got %0b expected 1", bus.dispense_valid); else n_pass++;
    bus.cancel = 1'b1;
    coin(7);
    bus.cancel = 1'b0;
    n_total++; if (bus.dispense_valid !== 1'b1 || bus.change_valid !== 1'b0) $display("FAIL extra_cancel_ignored: got valid=%0b change_valid=%0b expected 1 0", bus.dispense_valid, bus.change_valid); else n_pass++;
    bus.dispense_ready = 1'b1;
    tick();
    bus.dispense_ready = 1'b0;
    n_total++; if (bus.change_value !== 7'd7) $display("FAIL extra_change: got %0d expected 7", bus.change_value); else n_pass++;
    tick();
  endtask

  // Item 3, 10 inserted, then left alone in PAY.
  task automatic test_timeout();
    bit early;
    select(3);
    coin(10);
    early = 1'b0;
`ifdef VEND_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.change_valid === 1'b1) early = 1'b1;
    end
    n_total++; if (early !== 1'b0) $display("FAIL timeout_early: got early=1 expected 0"); else n_pass++;
    tick();
    n_total++; if (bus.change_valid !== 1'b1 || bus.change_value !== 7'd10) $display("FAIL timeout_refund: got valid=%0b value=%0d expected valid=1 value=10", bus.change_valid, bus.change_value); else n_pass++;
    tick();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL timeout_idle: got busy=%0b expected 0", bus.busy); else n_pass++;
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.change_valid === 1'b1) early = 1'b1;
    end
    n_total++; if (early !== 1'b0 || bus.busy !== 1'b1) $display("FAIL pay_waits: got settled=%0b busy=%0b expected 0 1", early, bus.busy); else n_pass++;
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    n_total++; if (bus.change_valid !== 1'b1 || bus.change_value !== 7'd10) $display("FAIL pay_cancel_refund: got valid=%0b value=%0d expected valid=1 value=10", bus.change_valid, bus.change_value); else n_pass++;
    tick();
`endif
  endtask

  // Reset while the dispense request is outstanding.
  task automatic test_reset_mid();
    select(2);
    coin(40);
    n_total++; if (bus.dispense_valid !== 1'b1 || bus.dispense_item !== 2'd2) $display("FAIL mid_dispense: got valid=%0b item=%0d expected valid=1 item=2", bus.dispense_valid, bus.dispense_item); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (bus.dispense_valid !== 1'b0 || bus.dispense_item !== 2'd0) $display("FAIL mid_rst_dispense: got valid=%0b item=%0d expected 0 0", bus.dispense_valid, bus.dispense_item); else n_pass++;
    n_total++; if (bus.change_valid !== 1'b0 || bus.change_value !== 7'd0) $display("FAIL mid_rst_change: got valid=%0b value=%0d expected 0 0", bus.change_valid, bus.change_value); else n_pass++;
    n_total++; if (bus.busy !== 1'b0 || bus.credit !== 7'd0) $display("FAIL mid_rst_state: got busy=%0b credit=%0d expected 0 0", bus.busy, bus.credit); else n_pass++;
    tick();
    n_total++; if (bus.change_valid !== 1'b0) $display("FAIL mid_rst_no_refund: got %0b expected 0", bus.change_valid); else n_pass++;
  endtask

  // Three-item instance: index 3 ignored, index 2 accepted.
  task automatic test_out_of_range();
    bus3.item_sel       = 2'd3;
    bus3.item_sel_valid = 1'b1;
    tick();
    bus3.item_sel_valid = 1'b0;
    n_total++; if (bus3.busy !== 1'b0) $display("FAIL oor_ignored: got busy=%0b expected 0", bus3.busy); else n_pass++;
    tick();
    n_total++; if (bus3.busy !== 1'b0) $display("FAIL oor_still_idle: got busy=%0b expected 0", bus3.busy); else n_pass++;
    bus3.item_sel       = 2'd2;
    bus3.item_sel_valid = 1'b1;
    tick();
    bus3.item_sel_valid = 1'b0;
    n_total++; if (bus3.busy !== 1'b1) $display("FAIL oor_in_range: got busy=%0b expected 1", bus3.busy); else n_pass++;
    bus3.cancel = 1'b1;
    tick();
    bus3.cancel = 1'b0;
    n_total++; if (bus3.change_valid !== 1'b1 || bus3.change_value !== 7'd0) $display("FAIL oor_zero_refund: got valid=%0b value=%0d expected valid=1 value=0", bus3.change_valid, bus3.change_value); else n_pass++;
    tick();
    n_total++; if (bus3.busy !== 1'b0) $display("FAIL oor_back_idle: got busy=%0b expected 0", bus3.busy); else n_pass++;
  endtask

  initial begin
    rst                 = 1'b1;
    total               = '0;
    bus.total_currency  = '0;
    bus.currency_ready  = 1'b0;
    bus.item_sel        = '0;
    bus.item_sel_valid  = 1'b0;
    bus.cancel          = 1'b0;
    bus.dispense_ready  = 1'b0;
    bus3.total_currency = '0;
    bus3.currency_ready = 1'b0;
    bus3.item_sel       = '0;
    bus3.item_sel_valid = 1'b0;
    bus3.cancel         = 1'b0;
    bus3.dispense_ready = 1'b0;
    test_reset();
    test_exact_pay();
    test_hold_stall();
    test_wrap();
    test_cancel_race();
    test_idle_cancel();
    test_dispense_extra();
    test_timeout();
    test_reset_mid();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
